ball_motion: RTL and testbench

Owns the ball's position and velocity and produces the ball_x/ball_y/ball_vx/ball_vy inputs consumed by brick_logic.
- Advances the ball once per video frame.
- Consumes brick_hit/hit_from_side from brick_logic to reflect the ball, and handles wall and paddle bounces, ball loss, serving and the lives count.
- Sits between the paddle/input logic and brick_logic; drives the renderer.

---
 rtl/game_pkg.sv | 45 ++++
 rtl/paddle_deflect.sv | 37 +++
 rtl/ball_motion.sv | 207 ++++++++++++++++++++
 tb/tb_ball_motion.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants and types, used by ball_motion, paddle_deflect and
// brick_logic.
//   - Screen, ball and paddle geometry in pixels.
//   - Velocity width.
//   - game_state encoding.
//   - A few small helpers for signed 12-bit motion arithmetic.
package game_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int BALL_SIZE     = 6;
    localparam int PADDLE_Y      = 448;
    localparam int PADDLE_WIDTH  = 64;
    localparam int LOST_FRAMES   = 60;
    localparam int LIVES         = 3;

    localparam int VEL_W      = 3;
    localparam int COORD_W    = 10;
    localparam int ARITH_W    = 12;
    localparam int LOST_CNT_W = $clog2(LOST_FRAMES);

    typedef enum logic [1:0] {
        GS_SERVE  = 2'd0,
        GS_MOVING = 2'd1,
        GS_LOST   = 2'd2,
        GS_OVER   = 2'd3
    } game_state_e;

    typedef logic signed [ARITH_W-1:0] arith_t;

    // Zero-extend an unsigned screen coordinate into the signed motion domain.
    function automatic arith_t coord_to_arith(input logic [COORD_W-1:0] v);
        return arith_t'($signed({1'b0, v}));
    endfunction

    // Sign-extend a velocity into the signed motion domain.
    function automatic arith_t vel_to_arith(input logic signed [VEL_W-1:0] v);
        return arith_t'(v);
    endfunction

    function automatic arith_t arith_abs(input arith_t v);
        return v[ARITH_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/paddle_deflect.sv
// Maps where the ball centre sits on the paddle to a new horizontal velocity.
// The paddle is split into four equal zones: -2, -1, +1, +2 (left to right).
// Ports:
//   ball_x_i   - ball left edge
//   paddle_x_i - paddle left edge
//   vx_o       - new horizontal velocity (signed)
module paddle_deflect
    import game_pkg::*;
(
    input  logic [COORD_W-1:0]      ball_x_i,
    input  logic [COORD_W-1:0]      paddle_x_i,
    output logic signed [VEL_W-1:0] vx_o
);

    localparam arith_t HALF_BALL_A = arith_t'(BALL_SIZE / 2);
    localparam arith_t Q1_A        = arith_t'(PADDLE_WIDTH / 4);
    localparam arith_t Q2_A        = arith_t'(PADDLE_WIDTH / 2);
    localparam arith_t Q3_A        = arith_t'((3 * PADDLE_WIDTH) / 4);

    arith_t off_a;

    always_comb begin
        // Offset of the ball centre from the paddle left edge; a negative
        // value (centre left of the paddle) falls into the leftmost zone.
        off_a = coord_to_arith(ball_x_i) + HALF_BALL_A - coord_to_arith(paddle_x_i);
        if (off_a < Q1_A) begin
            vx_o = VEL_W'(-2);
        end else if (off_a < Q2_A) begin
            vx_o = VEL_W'(-1);
        end else if (off_a < Q3_A) begin
            vx_o = VEL_W'(1);
        end else begin
            vx_o = VEL_W'(2);
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Owns ball position/velocity, serving, bounces, ball loss and lives.
// Motion advances only on frame_tick; all outputs are registered.
// Ports:
//   clk, rst (sync, active-low)
//   frame_tick            - one-cycle pulse per video frame
//   paddle_x              - paddle left edge
//   launch                - serve request
//   brick_hit, hit_from_side - reflection request from brick_logic
//   ball_x/ball_y         - ball top-left corner
//   ball_vx/ball_vy       - velocity in pixels/frame
//   ball_lost             - one-cycle pulse when a ball is lost
//   lives                 - remaining lives
//   game_state            - 0=SERVE 1=MOVING 2=LOST 3=OVER (FSM state)
module ball_motion
    import game_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic [COORD_W-1:0]      paddle_x,
    input  logic                    launch,
    input  logic                    brick_hit,
    input  logic                    hit_from_side,
    output logic [COORD_W-1:0]      ball_x,
    output logic [COORD_W-1:0]      ball_y,
    output logic signed [VEL_W-1:0] ball_vx,
    output logic signed [VEL_W-1:0] ball_vy,
    output logic                    ball_lost,
    output logic [1:0]              lives,
    output logic [1:0]              game_state
);

    localparam arith_t X_MAX_A     = arith_t'(SCREEN_WIDTH - BALL_SIZE);
    localparam arith_t Y_MAX_A     = arith_t'(SCREEN_HEIGHT - BALL_SIZE);
    localparam arith_t BALL_A      = arith_t'(BALL_SIZE);
    localparam arith_t PADDLE_Y_A  = arith_t'(PADDLE_Y);
    localparam arith_t PADDLE_W_A  = arith_t'(PADDLE_WIDTH);
    localparam arith_t SERVE_OFF_A = arith_t'(PADDLE_WIDTH / 2 - BALL_SIZE / 2);

    localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(SCREEN_WIDTH - BALL_SIZE);
    localparam logic [COORD_W-1:0] RESET_X_C = COORD_W'((SCREEN_WIDTH - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] SERVE_Y_C = COORD_W'(PADDLE_Y - BALL_SIZE);

    game_state_e             state_q;
    logic [COORD_W-1:0]      x_q, y_q;
    logic signed [VEL_W-1:0] vx_q, vy_q;
    logic [1:0]              lives_q;
    logic                    ball_lost_q;
    logic                    pend_x_q, pend_y_q;
    logic [LOST_CNT_W-1:0]   lost_cnt_q;

    // Brick hits arriving in the same cycle as frame_tick count for that tick.
    logic pend_x_eff, pend_y_eff;
    assign pend_x_eff = pend_x_q | (brick_hit & hit_from_side);
    assign pend_y_eff = pend_y_q | (brick_hit & ~hit_from_side);

    logic signed [VEL_W-1:0] deflect_vx;

    paddle_deflect u_deflect (
        .ball_x_i   (x_q),
        .paddle_x_i (paddle_x),
        .vx_o       (deflect_vx)
    );

    // Candidate next position/velocity for a MOVING frame.
    arith_t x_a, y_a, pad_a, vx_a, vy_a, nx_a, ny_a;
    arith_t vx_abs, vy_abs, vx_nabs, vy_nabs, serve_x_a;
    logic                    catch_w, lose_w;
    logic [COORD_W-1:0]      mv_x_d, mv_y_d, serve_x_d;
    logic signed [VEL_W-1:0] mv_vx_d, mv_vy_d;

    always_comb begin
        x_a     = coord_to_arith(x_q);
        y_a     = coord_to_arith(y_q);
        pad_a   = coord_to_arith(paddle_x);
        vx_a    = pend_x_eff ? -vel_to_arith(vx_q) : vel_to_arith(vx_q);
        vy_a    = pend_y_eff ? -vel_to_arith(vy_q) : vel_to_arith(vy_q);
        vx_abs  = arith_abs(vx_a);
        vy_abs  = arith_abs(vy_a);
        vx_nabs = -vx_abs;
        vy_nabs = -vy_abs;
        nx_a    = x_a + vx_a;
        ny_a    = y_a + vy_a;

        mv_x_d  = nx_a[COORD_W-1:0];
        mv_y_d  = ny_a[COORD_W-1:0];
        mv_vx_d = vx_a[VEL_W-1:0];
        mv_vy_d = vy_a[VEL_W-1:0];

        if (nx_a[ARITH_W-1]) begin
            mv_x_d  = '0;
            mv_vx_d = vx_abs[VEL_W-1:0];
        end else if (nx_a > X_MAX_A) begin
            mv_x_d  = X_MAX_C;
            mv_vx_d = vx_nabs[VEL_W-1:0];
        end

        if (ny_a[ARITH_W-1]) begin
            mv_y_d  = '0;
            mv_vy_d = vy_abs[VEL_W-1:0];
        end

        // Catch uses the pre-move position: the ball must start at or above
        // the paddle top and reach it this frame while overlapping it.
        catch_w = !vy_a[ARITH_W-1] && (vy_a != '0)
                  && (y_a + BALL_A <= PADDLE_Y_A)
                  && (ny_a + BALL_A >= PADDLE_Y_A)
                  && (x_a + BALL_A > pad_a)
                  && (x_a < pad_a + PADDLE_W_A);
        if (catch_w) begin
            mv_y_d  = SERVE_Y_C;
            mv_vy_d = vy_nabs[VEL_W-1:0];
            mv_vx_d = deflect_vx;
        end

        lose_w = (ny_a > Y_MAX_A) && !catch_w;

        serve_x_a = pad_a + SERVE_OFF_A;
        if (serve_x_a[ARITH_W-1]) begin
            serve_x_d = '0;
        end else if (serve_x_a > X_MAX_A) begin
            serve_x_d = X_MAX_C;
        end else begin
            serve_x_d = serve_x_a[COORD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= GS_SERVE;
            x_q         <= RESET_X_C;
            y_q         <= SERVE_Y_C;
            vx_q        <= '0;
            vy_q        <= '0;
            lives_q     <= 2'(LIVES);
            ball_lost_q <= 1'b0;
            pend_x_q    <= 1'b0;
            pend_y_q    <= 1'b0;
            lost_cnt_q  <= '0;
        end else begin
            ball_lost_q <= 1'b0;
            case (state_q)
                GS_SERVE: begin
                    pend_x_q <= 1'b0;
                    pend_y_q <= 1'b0;
                    if (frame_tick) begin
                        x_q <= serve_x_d;
                        y_q <= SERVE_Y_C;
                    end
                    if (launch) begin
                        state_q <= GS_MOVING;
                        vx_q    <= VEL_W'(1);
                        vy_q    <= VEL_W'(-2);
                    end
                end
                GS_MOVING: begin
                    if (frame_tick) begin
                        pend_x_q <= 1'b0;
                        pend_y_q <= 1'b0;
                        if (lose_w) begin
                            lives_q     <= lives_q - 2'd1;
                            ball_lost_q <= 1'b1;
                            vx_q        <= '0;
                            vy_q        <= '0;
                            lost_cnt_q  <= '0;
                            state_q     <= (lives_q == 2'd1) ? GS_OVER : GS_LOST;
                        end else begin
                            x_q  <= mv_x_d;
                            y_q  <= mv_y_d;
                            vx_q <= mv_vx_d;
                            vy_q <= mv_vy_d;
                        end
                    end else begin
                        pend_x_q <= pend_x_eff;
                        pend_y_q <= pend_y_eff;
                    end
                end
                GS_LOST: begin
                    pend_x_q <= 1'b0;
                    pend_y_q <= 1'b0;
                    if (frame_tick) begin
                        if (lost_cnt_q == LOST_CNT_W'(LOST_FRAMES - 1)) begin
                            lost_cnt_q <= '0;
                            state_q    <= GS_SERVE;
                        end else begin
                            lost_cnt_q <= lost_cnt_q + LOST_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    // GS_OVER: everything holds until reset.
                    pend_x_q <= 1'b0;
                    pend_y_q <= 1'b0;
                end
            endcase
        end
    end

    assign ball_x     = x_q;
    assign ball_y     = y_q;
    assign ball_vx    = vx_q;
    assign ball_vy    = vy_q;
    assign ball_lost  = ball_lost_q;
    assign lives      = lives_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed scenarios plus a randomized phase, every
// cycle compared against an integer reference model of the ball rules.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] paddle_x = '0;
    logic       launch = 1'b0;
    logic       brick_hit = 1'b0;
    logic       hit_from_side = 1'b0;

    logic [9:0]        ball_x, ball_y;
    logic signed [2:0] ball_vx, ball_vy;
    logic              ball_lost;
    logic [1:0]        lives, game_state;

    ball_motion dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .paddle_x      (paddle_x),
        .launch        (launch),
        .brick_hit     (brick_hit),
        .hit_from_side (hit_from_side),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .ball_vx       (ball_vx),
        .ball_vy       (ball_vy),
        .ball_lost     (ball_lost),
        .lives         (lives),
        .game_state    (game_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: 0=SERVE 1=MOVING 2=LOST 3=OVER.
    int m_state, m_x, m_y, m_vx, m_vy, m_lives, m_cnt, m_lost;
    bit m_px, m_py;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic m_step(input bit rstn, input bit tick, input bit lau,
                          input bit hit, input bit side, input int pad);
        int vx, vy, nx, ny, fx, fy, nvx, nvy, off;
        bit px, py, caught;
        if (!rstn) begin
            m_state = 0; m_x = 317; m_y = 442; m_vx = 0; m_vy = 0;
            m_lives = 3; m_cnt = 0; m_px = 0; m_py = 0; m_lost = 0;
            return;
        end
        m_lost = 0;
        case (m_state)
            0: begin
                m_px = 0; m_py = 0;
                if (tick) begin
                    m_x = (pad + 29 > 634) ? 634 : pad + 29;
                    m_y = 442;
                end
                if (lau) begin
                    m_state = 1; m_vx = 1; m_vy = -2;
                end
            end
            1: begin
                px = m_px || (hit && side);
                py = m_py || (hit && !side);
                if (!tick) begin
                    m_px = px; m_py = py;
                end else begin
                    m_px = 0; m_py = 0;
                    vx = px ? -m_vx : m_vx;
                    vy = py ? -m_vy : m_vy;
                    nx = m_x + vx; ny = m_y + vy;
                    fx = nx; fy = ny; nvx = vx; nvy = vy;
                    if (nx < 0) begin
                        fx = 0; nvx = iabs(vx);
                    end else if (nx > 634) begin
                        fx = 634; nvx = -iabs(vx);
                    end
                    if (ny < 0) begin
                        fy = 0; nvy = iabs(vy);
                    end
                    caught = (vy > 0) && (m_y + 6 <= 448) && (ny + 6 >= 448)
                             && (m_x + 6 > pad) && (m_x < pad + 64);
                    if (caught) begin
                        fy = 442; nvy = -iabs(vy);
                        off = m_x + 3 - pad;
                        nvx = (off < 16) ? -2 : (off < 32) ? -1 : (off < 48) ? 1 : 2;
                    end
                    if (ny > 474 && !caught) begin
                        m_lives = m_lives - 1; m_lost = 1;
                        m_vx = 0; m_vy = 0; m_cnt = 0;
                        m_state = (m_lives == 0) ? 3 : 2;
                    end else begin
                        m_x = fx; m_y = fy; m_vx = nvx; m_vy = nvy;
                    end
                end
            end
            2: begin
                m_px = 0; m_py = 0;
                if (tick) begin
                    m_cnt++;
                    if (m_cnt == 60) begin
                        m_state = 0; m_cnt = 0;
                    end
                end
            end
            default: begin
                m_px = 0; m_py = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("x", ball_x, m_x);
        check_eq("y", ball_y, m_y);
        check_eq("vx", ball_vx, m_vx);
        check_eq("vy", ball_vy, m_vy);
        check_eq("lost", ball_lost, m_lost);
        check_eq("lives", lives, m_lives);
        check_eq("state", game_state, m_state);
    endtask

    // One clock: drive, step the model at the edge, compare #1 after it.
    task automatic cyc(input bit tick, input bit lau, input bit hit, input bit side);
        frame_tick = tick; launch = lau; brick_hit = hit; hit_from_side = side;
        @(posedge clk);
        m_step(rst, tick, lau, hit, side, int'(paddle_x));
        #1;
        frame_tick = 1'b0; launch = 1'b0; brick_hit = 1'b0; hit_from_side = 1'b0;
        compare_all();
    endtask

    task automatic frame(input bit hit, input bit side);
        cyc(1'b1, 1'b0, hit, side);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    // Serve if needed, then keep the paddle away until the ball is lost.
    task automatic lose_one(input int exp_lives);
        bit done;
        done = 0;
        if (m_state == 0) begin
            frame(1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 1500 && !done; i++) begin
            paddle_x = (m_x > 320) ? 10'd0 : 10'd576;
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (m_lost != 0) begin
                done = 1;
                check_eq("lost_pulse", ball_lost, 1);
                check_eq("lives_after_loss", lives, exp_lives);
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                check_eq("lost_one_cycle", ball_lost, 0);
            end else begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        check_eq("loss_reached", done, 1);
    endtask

    initial begin
        bit caught_seen;
        int pv;

        // Reset and serve tracking.
        do_reset();
        check_eq("rst_x", ball_x, 317);
        check_eq("rst_y", ball_y, 442);
        check_eq("rst_state", game_state, 0);
        check_eq("rst_lives", lives, 3);
        paddle_x = 10'd288;
        frame(1'b0, 1'b0);
        check_eq("serve_x", ball_x, 317);
        check_eq("serve_vx", ball_vx, 0);

        // Launch and first motion frame.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check_eq("launch_x", ball_x, 318);
        check_eq("launch_y", ball_y, 440);
        check_eq("launch_vx", ball_vx, 1);
        check_eq("launch_vy", ball_vy, -2);

        // Right wall.
        do_reset();
        paddle_x = 10'd576;
        frame(1'b0, 1'b0);
        check_eq("serve_clamp_x", ball_x, 605);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 29; i++) frame(1'b0, 1'b0);
        check_eq("wall29_x", ball_x, 634);
        check_eq("wall29_y", ball_y, 384);
        frame(1'b0, 1'b0);
        check_eq("wall30_x", ball_x, 634);
        check_eq("wall30_vx", ball_vx, -1);
        check_eq("wall30_y", ball_y, 382);

        // Brick bounces: between ticks, side hit, and coincident with a tick.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b0);
        check_eq("brick_vy", ball_vy, 2);
        check_eq("brick_y", ball_y, 384);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        frame(1'b0, 1'b0);
        check_eq("brick_side_vx", ball_vx, 1);
        frame(1'b1, 1'b0);
        check_eq("brick_coinc_vy", ball_vy, -2);
        check_eq("brick_coinc_y", ball_y, 384);

        // Paddle catch near the left edge of the paddle: expect vx=-2.
        caught_seen = 0;
        for (int i = 0; i < 600 && !caught_seen; i++) begin
            paddle_x = (m_x >= 7) ? 10'(m_x - 7) : 10'd0;
            pv = m_vy;
            frame(1'b0, 1'b0);
            if (pv > 0 && m_vy < 0 && m_state == 1) begin
                caught_seen = 1;
                check_eq("catch_y", ball_y, 442);
                check_eq("catch_vx", ball_vx, -2);
                check_eq("catch_vy", ball_vy, -2);
            end
        end
        check_eq("catch_seen", caught_seen, 1);

        // Loss, LOST timeout, and game over.
        do_reset();
        paddle_x = 10'd288;
        for (int k = 1; k <= 3; k++) begin
            lose_one(3 - k);
            if (k < 3) begin
                check_eq("lost_state", game_state, 2);
                cyc(1'b0, 1'b1, 1'b0, 1'b0);
                for (int t = 0; t < 59; t++) frame(1'b0, 1'b0);
                check_eq("lost_59", game_state, 2);
                frame(1'b0, 1'b0);
                check_eq("lost_60_serve", game_state, 0);
            end
        end
        check_eq("over_state", game_state, 3);
        check_eq("over_lives", lives, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 5; t++) frame(1'b0, 1'b0);
        check_eq("over_launch_ignored", game_state, 3);

        // Reset in the middle of LOST.
        do_reset();
        lose_one(2);
        for (int t = 0; t < 10; t++) frame(1'b0, 1'b0);
        do_reset();
        check_eq("midlost_rst_state", game_state, 0);
        check_eq("midlost_rst_lives", lives, 3);
        check_eq("midlost_rst_x", ball_x, 317);
        check_eq("midlost_rst_y", ball_y, 442);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    paddle_x = 10'($urandom_range(0, 639));
                end else begin
                    pv = m_x + 3 - 32 + int'($urandom_range(0, 60)) - 30;
                    paddle_x = (pv < 0) ? 10'd0 : (pv > 576) ? 10'd576 : 10'(pv);
                end
            end
            if ($urandom_range(0, 999) == 0 || (m_state == 3 && $urandom_range(0, 49) == 0))
                rst = 1'b0;
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
            rst = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
